// File: rtl/sd_resp_rx.sv
// sd_resp_rx: SD CMD-line response receiver; optional CRC7 check enabled by macro SD_RSP_CRC_CHECK_EN
module sd_resp_rx #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_in,
  input  logic         start,
  input  logic [2:0]   resp_type,
  input  logic [5:0]   cmd_index,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic         end_err,
  output logic         index_err,
  output logic [127:0] long_out,
  output logic [31:0]  ocr_out,
  output logic [15:0]  rca_out,
  output logic [63:0]  stat_out,
  output logic         cid_en,
  output logic         csd_en,
  output logic         ocr_en,
  output logic         rca_en,
  output logic         stat_en
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RECV, FINISH} state_t;
  state_t state, next_state;
  logic [2:0] rtype;
  logic [5:0] idx;
  logic [CW-1:0] cnt;
  logic [7:0] pos;
  logic [133:0] frame;
  logic [134:0] f;
  logic [5:0] chk;
  logic long_f, last, tmo, tbit, idx_bad, end_bad, crc_bad, ok;

  assign busy = state != IDLE;

  // Frame view including the bit on the line now, plus end-of-frame checks
  always_comb begin
    long_f = rtype == 3'd1 || rtype == 3'd2;
    f = {frame, cmd_in};
    last = state == RECV && pos == (long_f ? 8'd135 : 8'd47);
    tmo = state == WAIT && cmd_in && cnt == CW'(TIMEOUT_CYCLES - 1);
    tbit = long_f ? f[134] : f[46];
    chk = long_f ? f[133:128] : f[45:40];
    idx_bad = tbit | ((rtype == 3'd0 || rtype == 3'd4) ? chk != idx : chk != 6'h3f);
    end_bad = ~cmd_in;
    ok = !idx_bad && !end_bad && !crc_bad;
  end

`ifdef SD_RSP_CRC_CHECK_EN
  logic [6:0] crc;
  logic fb, covered;
  assign fb = crc[6] ^ cmd_in;
  assign covered = state == RECV && (long_f ? pos >= 8'd8 && pos <= 8'd127 : pos <= 8'd39);
  assign crc_bad = rtype != 3'd3 && crc != f[7:1];
  // Serial CRC7 (x^7+x^3+1); the start bit is zero so seeding with 0 while waiting covers it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) crc <= '0;
    else if (state == WAIT) crc <= '0;
    else if (covered) crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  end
`else
  assign crc_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? (resp_type > 3'd4 ? FINISH : WAIT) : IDLE;
      WAIT:    next_state = !cmd_in ? RECV : tmo ? FINISH : WAIT;
      RECV:    next_state = last ? FINISH : RECV;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: counters, frame shift, error flags, register-file data and strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rtype <= '0;
      idx <= '0;
      cnt <= '0;
      pos <= '0;
      frame <= '0;
      done <= 1'b0;
      {timeout_err, crc_err, end_err, index_err} <= '0;
      {cid_en, csd_en, ocr_en, rca_en, stat_en} <= '0;
      long_out <= '0;
      ocr_out <= '0;
      rca_out <= '0;
      stat_out <= '0;
    end else begin
      done <= 1'b0;
      {cid_en, csd_en, ocr_en, rca_en, stat_en} <= '0;
      if (state == IDLE && start) begin
        rtype <= resp_type;
        idx <= cmd_index;
        cnt <= '0;
        {timeout_err, crc_err, end_err, index_err} <= '0;
        done <= resp_type > 3'd4;
      end
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        pos <= 8'd1;
        frame <= '0;
        timeout_err <= tmo;
        done <= tmo;
      end
      if (state == RECV) begin
        frame <= f[133:0];
        pos <= pos + 8'd1;
        if (last) begin
          done <= 1'b1;
          index_err <= idx_bad;
          end_err <= end_bad;
          crc_err <= crc_bad;
          cid_en <= ok && rtype == 3'd1;
          csd_en <= ok && rtype == 3'd2;
          ocr_en <= ok && rtype == 3'd3;
          rca_en <= ok && rtype == 3'd4;
          stat_en <= ok && (rtype == 3'd0 || rtype == 3'd4);
          if (ok && long_f) long_out <= {f[127:1], 1'b1};
          if (ok && rtype == 3'd3) ocr_out <= f[39:8];
          if (ok && rtype == 3'd4) rca_out <= f[39:24];
          if (ok && (rtype == 3'd0 || rtype == 3'd4)) stat_out <= {26'b0, f[45:40], f[39:8]};
        end
      end
    end
  end
endmodule
